// File: rtl/dec_2_bin_pkg.sv
// Shared definitions for dec_2_bin: FSM states, 7-segment patterns, anode codes
// and the BCD-pair to binary helper.
package dec_2_bin_pkg;

   typedef enum logic [1:0] {
      WAIT_TENS  = 2'd0,
      WAIT_UNITS = 2'd1,
      SHOW       = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK   = 7'b1111111;
   localparam logic [3:0] ANODE_TENS  = 4'b1101;
   localparam logic [3:0] ANODE_UNITS = 4'b1110;
   localparam logic [3:0] BCD_MAX     = 4'd9;

   // Active-low cathodes ordered {a,b,c,d,e,f,g}
   function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // tens*10 + units via shifts; 7 bits holds 99 without truncation
   function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
      logic [6:0] t7;
      logic [6:0] u7;
      t7 = {3'b000, tens};
      u7 = {3'b000, units};
      return (t7 << 3'd3) + (t7 << 3'd1) + u7;
   endfunction

endpackage

// File: rtl/dec_2_bin_seg7_decode.sv
// seg7_decode: maps one BCD digit plus a blank flag to active-low cathodes.
module seg7_decode
   import dec_2_bin_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] segments
);

   // Uncaptured digits are shown dark
   always_comb begin
      if (blank) begin
         segments = SEG_BLANK;
      end else begin
         segments = seg_pattern(bcd);
      end
   end

endmodule

// File: rtl/dec_2_bin.sv
// dec_2_bin: two-digit BCD entry via switches and a push-button, binary result
// and multiplexed 7-segment display. Optional debounce: DEC_2_BIN_DEBOUNCE_EN.
module dec_2_bin
   import dec_2_bin_pkg::*;
#(
   parameter int DEBOUNCE_BITS = 20,
   parameter int REFRESH_BIT   = 18
) (
   input  logic       clock_100Mhz,
   input  logic       reset_n,
   input  logic [3:0] switch,
   input  logic       enter_btn,
   output logic [6:0] binary_out,
   output logic       valid,
   output logic       error,
   output logic [3:0] Anode_Activate,
   output logic [6:0] LED_out
);

   localparam logic [19:0] REFRESH_ONE = 20'd1;

   logic        sync1_r, sync2_r;
   logic        level_s, level_prev_r, accept_s;
   state_t      state_r, next_state_s;
   logic        take_tens_s, take_units_s, reject_s;
   logic [3:0]  tens_r, units_r;
   logic        tens_ok_r, units_ok_r;
   logic [6:0]  binary_r;
   logic        valid_r, error_r;
   logic [19:0] refresh_r;
   logic        sel_units_s, blank_s;
   logic [3:0]  digit_s;

   // Two-flop synchronizer for the raw button
   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= enter_btn;
         sync2_r <= sync1_r;
      end
   end

`ifdef DEC_2_BIN_DEBOUNCE_EN
   localparam logic [DEBOUNCE_BITS-1:0] DB_ONE  = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
   localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};

   logic [DEBOUNCE_BITS-1:0] db_cnt_r;
   logic                     db_level_r;

   // Level follows the input only after 2^N-1 consecutive differing cycles
   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_r   <= '0;
         db_level_r <= 1'b0;
      end else if (sync2_r != db_level_r) begin
         if (db_cnt_r == DB_LAST) begin
            db_level_r <= sync2_r;
            db_cnt_r   <= '0;
         end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
         end
      end else begin
         db_cnt_r <= '0;
      end
   end

   assign level_s = db_level_r;
`else
   assign level_s = sync2_r;
`endif

   // Rising edge of the conditioned level gives one accept per press
   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         level_prev_r <= 1'b0;
      end else begin
         level_prev_r <= level_s;
      end
   end

   assign accept_s = level_s & ~level_prev_r;

   // FSM state register
   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= WAIT_TENS;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state and capture strobes; non-BCD digits leave state untouched
   always_comb begin
      next_state_s = state_r;
      take_tens_s  = 1'b0;
      take_units_s = 1'b0;
      reject_s     = 1'b0;
      if (accept_s) begin
         if (switch > BCD_MAX) begin
            reject_s = 1'b1;
         end else begin
            case (state_r)
               WAIT_TENS: begin
                  take_tens_s  = 1'b1;
                  next_state_s = WAIT_UNITS;
               end
               WAIT_UNITS: begin
                  take_units_s = 1'b1;
                  next_state_s = SHOW;
               end
               SHOW: begin
                  take_tens_s  = 1'b1;
                  next_state_s = WAIT_UNITS;
               end
               default: begin
                  next_state_s = WAIT_TENS;
               end
            endcase
         end
      end else begin
         next_state_s = state_r;
      end
   end

   // Captured digits and registered outputs
   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         tens_r     <= 4'd0;
         units_r    <= 4'd0;
         tens_ok_r  <= 1'b0;
         units_ok_r <= 1'b0;
         binary_r   <= 7'd0;
         valid_r    <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         if (reject_s) begin
            error_r <= 1'b1;
         end else if (take_tens_s || take_units_s) begin
            error_r <= 1'b0;
         end
         if (take_tens_s) begin
            tens_r     <= switch;
            tens_ok_r  <= 1'b1;
            units_ok_r <= 1'b0;
            valid_r    <= 1'b0;
         end
         if (take_units_s) begin
            units_r    <= switch;
            units_ok_r <= 1'b1;
            valid_r    <= 1'b1;
            binary_r   <= bcd_to_bin(tens_r, switch);
         end
      end
   end

   // Free-running display refresh counter
   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         refresh_r <= 20'd0;
      end else begin
         refresh_r <= refresh_r + REFRESH_ONE;
      end
   end

   assign sel_units_s = refresh_r[REFRESH_BIT];

   // Digit multiplexing
   always_comb begin
      if (sel_units_s) begin
         Anode_Activate = ANODE_UNITS;
         digit_s        = units_r;
         blank_s        = ~units_ok_r;
      end else begin
         Anode_Activate = ANODE_TENS;
         digit_s        = tens_r;
         blank_s        = ~tens_ok_r;
      end
   end

   seg7_decode u_seg7_decode (
      .bcd      (digit_s),
      .blank    (blank_s),
      .segments (LED_out)
   );

   assign binary_out = binary_r;
   assign valid      = valid_r;
   assign error      = error_r;

endmodule

// File: tb/tb_dec_2_bin.sv
// Self-checking bench for dec_2_bin with a scoreboard of expected conversions.
module tb_dec_2_bin;

   localparam int DB_BITS = 4;
   localparam int RB      = 2;
   localparam int HOLD    = 20;
   localparam int REL     = 25;
`ifdef DEC_2_BIN_DEBOUNCE_EN
   localparam int LAT = 18;
`else
   localparam int LAT = 3;
`endif
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       clk;
   logic       reset_n;
   logic [3:0] switch;
   logic       enter_btn;
   logic [6:0] binary_out;
   logic       valid;
   logic       error;
   logic [3:0] anode;
   logic [6:0] led;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];
   logic [19:0] ref_cnt;

   dec_2_bin #(.DEBOUNCE_BITS(DB_BITS), .REFRESH_BIT(RB)) dut (
      .clock_100Mhz   (clk),
      .reset_n        (reset_n),
      .switch         (switch),
      .enter_btn      (enter_btn),
      .binary_out     (binary_out),
      .valid          (valid),
      .error          (error),
      .Anode_Activate (anode),
      .LED_out        (led)
   );

   always #5 clk = ~clk;

   // Reference refresh counter to know which digit is on display
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) ref_cnt <= 20'd0;
      else          ref_cnt <= ref_cnt + 20'd1;
   end

   function automatic logic [6:0] exp_seg(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return BLANK;
      endcase
   endfunction

   task automatic press(input logic [3:0] d, output int lat);
      logic pre;
      @(negedge clk);
      switch = d;
      enter_btn = 1'b1;
      pre = valid;
      lat = -1;
      for (int i = 1; i <= HOLD; i++) begin
         @(posedge clk); #1;
         if (lat < 0 && valid !== pre) lat = i;
      end
      @(negedge clk);
      enter_btn = 1'b0;
      repeat (REL) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_display(input string name, input logic [6:0] exp_t, input logic [6:0] exp_u);
      int n;
      n = 0;
      while (ref_cnt[RB] !== 1'b0 && n < 16) begin @(posedge clk); #1; n++; end
      checks++;
      if (anode !== 4'b1101 || led !== exp_t) begin
         errors++;
         $display("FAIL %s_tens: anode %b led %b, expected anode 1101 led %b", name, anode, led, exp_t);
      end
      n = 0;
      while (ref_cnt[RB] !== 1'b1 && n < 16) begin @(posedge clk); #1; n++; end
      checks++;
      if (anode !== 4'b1110 || led !== exp_u) begin
         errors++;
         $display("FAIL %s_units: anode %b led %b, expected anode 1110 led %b", name, anode, led, exp_u);
      end
   endtask

   task automatic pop_compare(input string name);
      logic [6:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s_sb: scoreboard empty, got %0d", name, binary_out);
      end else begin
         exp = exp_q.pop_front();
         if (valid !== 1'b1 || binary_out !== exp) begin
            errors++;
            $display("FAIL %s_result: got valid %b value %0d, expected valid 1 value %0d", name, valid, binary_out, exp);
         end
      end
   endtask

   task automatic enter_number(input string name, input int t, input int u);
      int lat;
      exp_q.push_back(7'(t * 10 + u));
      press(4'(t), lat);
      press(4'(u), lat);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, LAT);
      end
      pop_compare(name);
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (binary_out !== 7'd0 || valid !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: got %0d/%b/%b, expected 0/0/0", binary_out, valid, error);
      end
      checks++;
      if (anode !== 4'b1101 || led !== BLANK) begin
         errors++;
         $display("FAIL reset_display: got %b/%b, expected 1101/%b", anode, led, BLANK);
      end
      switch = 4'd5;
      enter_btn = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (anode !== 4'b1101 || led !== BLANK || valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_held: got %b/%b/%b, expected 1101/%b/0", anode, led, valid, BLANK);
      end
      enter_btn = 1'b0;
      repeat (40) @(posedge clk);
      pulse_reset();
   endtask

   task automatic test_convert_42();
      enter_number("conv42", 4, 2);
      check_display("conv42", exp_seg(4), exp_seg(2));
   endtask

   task automatic test_boundaries();
      enter_number("conv99", 9, 9);
      checks++;
      if (binary_out !== 7'b1100011) begin
         errors++;
         $display("FAIL conv99_bits: got %b, expected 1100011", binary_out);
      end
      enter_number("conv00", 0, 0);
      check_display("conv00", exp_seg(0), exp_seg(0));
   endtask

   task automatic test_error();
      int lat;
      exp_q.push_back(7'd45);
      press(4'd4, lat);
      press(4'd12, lat);
      checks++;
      if (error !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL err_set: got error %b valid %b, expected 1/0", error, valid);
      end
      check_display("err_wait_units", exp_seg(4), BLANK);
      press(4'd5, lat);
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got %b, expected 0", error);
      end
      pop_compare("err45");
   endtask

   task automatic test_show_new_tens();
      int lat;
      enter_number("show42", 4, 2);
      press(4'd7, lat);
      checks++;
      if (valid !== 1'b0 || binary_out !== 7'd42) begin
         errors++;
         $display("FAIL show_new_tens: got valid %b value %0d, expected 0/42", valid, binary_out);
      end
      check_display("show_new_tens", exp_seg(7), BLANK);
   endtask

   task automatic test_debounce();
      int lat;
      pulse_reset();
      switch = 4'd3;
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         enter_btn = 1'b1;
         repeat (5) @(negedge clk);
         enter_btn = 1'b0;
         repeat (5) @(negedge clk);
      end
      repeat (20) @(posedge clk);
      #1;
      check_display("glitch", BLANK, BLANK);
      press(4'd3, lat);
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_single_accept: got valid %b, expected 0", valid);
      end
      check_display("hold", exp_seg(3), BLANK);
   endtask

   task automatic test_reset_mid();
      int lat;
      pulse_reset();
      enter_number("pre_rst", 4, 2);
      press(4'd13, lat);
      press(4'd6, lat);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (binary_out !== 7'd0 || valid !== 1'b0 || error !== 1'b0 || anode !== 4'b1101 || led !== BLANK) begin
         errors++;
         $display("FAIL mid_reset: got %0d/%b/%b/%b/%b, expected 0/0/0/1101/%b",
                  binary_out, valid, error, anode, led, BLANK);
      end
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.push_back(7'd81);
      press(4'd8, lat);
      check_display("after_rst", exp_seg(8), BLANK);
      press(4'd1, lat);
      pop_compare("after_rst81");
   endtask

   initial begin
      clk = 1'b0;
      reset_n = 1'b0;
      switch = 4'd0;
      enter_btn = 1'b0;
      test_reset();
      test_convert_42();
      test_boundaries();
      test_error();
      test_show_new_tens();
`ifdef DEC_2_BIN_DEBOUNCE_EN
      test_debounce();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dec_2_bin.md
DEC_2_BIN -- requirements
Module: dec_2_bin

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_BITS, default 20, setting the debounce counter width; a level must be stable for 2^DEBOUNCE_BITS-1 cycles.
REQ-002 The block SHALL have parameter REFRESH_BIT, default 18, giving the refresh_counter bit that selects the displayed digit.
REQ-003 The block SHALL have port clock_100Mhz, input, 1 bit: the single clock, 100 MHz Basys 3 source.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port switch, input, 4 bits: the BCD digit being entered.
REQ-006 The block SHALL have port enter_btn, input, 1 bit: raw, asynchronous push-button; a press commits switch as a digit.
REQ-007 The block SHALL have port binary_out, output, 7 bits: the converted value, 0..99.
REQ-008 The block SHALL have port valid, output, 1 bit: high while binary_out holds a complete conversion.
REQ-009 The block SHALL have port error, output, 1 bit: the last press was rejected as a non-BCD digit.
REQ-010 The block SHALL have port Anode_Activate, output, 4 bits: active-low 7-seg anodes.
REQ-011 The block SHALL have port LED_out, output, 7 bits: active-low cathodes {a..g}.

Function
REQ-012 enter_btn SHALL pass through a 2-flop synchronizer; a press is the rising edge of the conditioned level, giving one single-cycle accept pulse per press regardless of hold time.
REQ-013 The FSM SHALL have states WAIT_TENS, WAIT_UNITS and SHOW; reset enters WAIT_TENS.
REQ-014 WAIT_TENS + accept with switch<=9: capture tens, error<=0, go to WAIT_UNITS.
REQ-015 WAIT_UNITS + accept with switch<=9: capture units, error<=0, go to SHOW; binary_out = tens*10+units and valid=1 on the same clock edge as the state change, one cycle after the accept pulse.
REQ-016 The multiply SHALL be (tens<<3)+(tens<<1)+units in at least 7 bits, with no truncation at 99.
REQ-017 SHOW + accept with switch<=9: valid<=0, binary_out held, capture new tens, clear units-captured, go to WAIT_UNITS.
REQ-018 An accept in any state with switch>9 (10..15) SHALL set error<=1 and change neither state nor captured digits, binary_out or valid.
REQ-019 Display: refresh_counter is 20 bits and free-running; bit REFRESH_BIT=0 selects Anode_Activate=1101 (tens), =1 selects 1110 (units); the other anodes stay 1.
REQ-020 A digit not yet captured SHALL be displayed blank (1111111); captured digits SHALL use the standard 0-9 active-low patterns.

Reset
REQ-021 With reset_n low: binary_out=0, valid=0, error=0, state WAIT_TENS, both digits uncaptured, refresh_counter=0, synchronizer/debounce flops 0.
REQ-022 While reset_n is low, combinational outputs SHALL give Anode_Activate=1101 and LED_out=1111111.
REQ-023 Reset asserted mid-entry SHALL discard partial digits immediately.
REQ-024 No press SHALL be registered on the first edge after reset release, even with the button held.

Configuration
REQ-025 The feature SHALL be controlled by macro DEC_2_BIN_DEBOUNCE_EN.
REQ-026 With DEC_2_BIN_DEBOUNCE_EN defined, the conditioned level SHALL update only after the synchronized input differs from it for 2^DEBOUNCE_BITS-1 consecutive cycles; any reversion restarts the counter.
REQ-027 Without DEC_2_BIN_DEBOUNCE_EN, the conditioned level SHALL be the synchronizer output directly.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the 0-9 segment patterns, the blank pattern and the anode codes 1101/1110.
REQ-029 Sub-module seg7_decode SHALL map a 4-bit BCD value plus blank flag to LED_out, and SHALL be instantiated once.

Verification
REQ-030 Bench SHALL cover: press 4 then 2 -> binary_out=42 (0101010), valid=1 one cycle after the second accept; display shows "4","2".
REQ-031 Bench SHALL cover: press 9, 9 -> binary_out=99 (1100011), no overflow; press 0, 0 -> binary_out=0, valid=1.
REQ-032 Bench SHALL cover: in WAIT_UNITS press switch=12 -> error=1, state stays WAIT_UNITS; then press 5 -> error=0, SHOW.
REQ-033 Bench SHALL cover: in SHOW with 42, press 7 -> valid=0, binary_out stays 42, tens shows "7", units blank.
REQ-034 Bench SHALL cover: with DEBOUNCE_BITS=4 and the macro on, 5-cycle glitches -> no accept; a 20-cycle hold -> exactly one accept.
REQ-035 Bench SHALL cover: reset_n pulsed low after the tens digit -> all outputs at reset values asynchronously; the next press is captured as tens.
